instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Pipeline IF stage: owns the program counter and instruction memory, and produces the PC+4 / instruction pair registered by the IF/ID pipeline register. It applies stall, branch and jump redirects. It stops fetching when the halt instruction is reached. The debug unit loads programs through a dedicated write port and gates execution with its clock enable.

## Interface
- NB_REG, 32, data/address width
- NB_ADDR, 8, instruction-memory word-address width (depth 2^NB_ADDR words)
- i_clk  in  1  rising-edge clock
- i_reset_n  in  1  asynchronous active-low reset
- i_dunit_clk_en  in  1  debug-unit execution enable; 0 freezes PC and FSM
- i_pc_write  in  1  hazard unit; 0 = stall (PC holds)
- i_branch_taken  in  1  branch resolved taken
- i_branch_addr  in  NB_REG  branch target (byte address)
- i_jump  in  1  jump/jr redirect
- i_jump_addr  in  NB_REG  jump target (byte address)
- i_imem_we  in  1  debug-unit instruction write strobe
- i_imem_waddr  in  NB_ADDR  word address to write
- i_imem_wdata  in  NB_REG  instruction word to write
- o_pc  out  NB_REG  current PC
- o_pc_four  out  NB_REG  PC+4, to IF/ID
- o_instruction  out  NB_REG  imem[PC word index], to IF/ID
- o_halted  out  1  fetch halted

## Operation
- PC is a byte address. Word index = PC[NB_ADDR+1:2]. Upper bits are ignored, so fetch wraps modulo depth.
- Targets are written to PC with bits [1:0] forced to 0.
- Next-PC priority: jump > branch > halt hold > PC+4.
- PC+4 is computed modulo 2^NB_REG (0xFFFFFFFC -> 0).
- The PC advances only when i_dunit_clk_en & i_pc_write & state==RUN.
- Redirects during a stall or with clk_en=0 are not latched; the hazard unit re-presents them.
- FSM states:
  - RUN -> HALTED when advancing with no redirect and o_instruction == HALT_INSTR (32'hFFFF_FFFF); the PC stays on the halt word.
  - HALTED -> RUN only on reset.
  - In HALTED: PC frozen, o_halted=1, o_instruction keeps presenting HALT_INSTR.
- Redirect coinciding with a halt fetch: the redirect wins, the FSM stays RUN, and the halt word is squashed by the IF/ID flush.
- Imem write: synchronous on i_clk when i_imem_we. It is independent of clk_en, stall and FSM state, and allowed while halted.
- Reset does not clear imem contents.

## Timing
- Reset values: PC=0, state RUN, o_halted=0, o_pc_four=4, o_instruction=imem[0].
- o_pc_four and o_instruction are combinational from the PC: zero latency, and IF/ID samples them on the same edge.
- A redirect asserted in cycle N makes PC=target after edge N; the fetched word appears in cycle N+1.
- o_halted rises after the edge on which the halt word was accepted.
- Write to the word currently being fetched: old data before the edge, new data after it. No bypass.
- Asynchronous reset mid-run or mid-halt returns all state immediately to reset values. Imem is unaffected.

## Configuration
- INSTRUCTION_FETCH_HALT_DETECT_EN
  - Defined: FSM and halt detection as above.
  - Undefined: no FSM, o_halted tied 0, and HALT_INSTR is fetched as an ordinary word with the PC advancing past it.

## Structure
- Shared package holds:
  - HALT_INSTR
  - NOP_INSTR (32'h0)
  - FSM state encoding (RUN=1'b0, HALTED=1'b1)
  - PC reset value (0)
  - Word increment (4)
- One sub-module, instruction_memory: 2^NB_ADDR x NB_REG array with synchronous write and asynchronous read; no reset.
- PC register, next-PC mux and FSM stay in instruction_fetch.

## Test plan
- Load imem[0..3]=0x20010001,0x20020002,0x20030003,0xFFFFFFFF, release reset, clk_en=1, pc_write=1 -> o_pc 0,4,8,12 then holds at 12; o_halted=1 from the cycle after PC=12 is accepted.
- At PC=8 pulse i_pc_write=0 for 2 cycles -> PC stays 8 and o_instruction stays 0x20030003; PC=12 on the first edge after release.
- At PC=4 assert i_branch_taken=1 with i_branch_addr=0x22 and i_jump=1 with i_jump_addr=0x40 -> next PC=0x40 (jump wins). Branch alone -> next PC=0x20.
- With PC on the halt word (0xFFFFFFFF) and i_jump=1, i_jump_addr=0 in the same cycle -> PC=0 and o_halted stays 0.
- While halted, write imem[3]=0x00000000 and pulse i_reset_n low -> PC=0, o_halted=0; the rerun passes address 12 and reaches PC=16.
- clk_en=0 for 5 cycles with pc_write=1 -> PC unchanged; an imem write during this window is still visible after it.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and FSM encoding for the IF stage.
package instruction_fetch_pkg;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] PC_RESET   = 32'h0000_0000;
    localparam logic [31:0] PC_INC     = 32'd4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: synchronous write from the debug unit, asynchronous read for fetch.
module instruction_memory #(
    parameter int unsigned NB_REG  = 32,
    parameter int unsigned NB_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_REG-1:0]  i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_REG-1:0]  o_rdata
);

    logic [NB_REG-1:0] r_mem [2**NB_ADDR];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC selection and halt FSM around the instruction memory.
// Halt detection is built only when INSTRUCTION_FETCH_HALT_DETECT_EN is defined.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned NB_REG  = 32,
    parameter int unsigned NB_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_dunit_clk_en,
    input  logic               i_pc_write,
    input  logic               i_branch_taken,
    input  logic [NB_REG-1:0]  i_branch_addr,
    input  logic               i_jump,
    input  logic [NB_REG-1:0]  i_jump_addr,
    input  logic               i_imem_we,
    input  logic [NB_ADDR-1:0] i_imem_waddr,
    input  logic [NB_REG-1:0]  i_imem_wdata,
    output logic [NB_REG-1:0]  o_pc,
    output logic [NB_REG-1:0]  o_pc_four,
    output logic [NB_REG-1:0]  o_instruction,
    output logic               o_halted
);

    logic [NB_REG-1:0]  r_pc;
    logic [NB_REG-1:0]  w_pc_four;
    logic [NB_REG-1:0]  w_pc_next;
    logic [NB_REG-1:0]  w_instruction;
    logic [NB_ADDR-1:0] w_word_idx;
    logic               w_advance;

    // Bits above the word index are ignored, so fetch wraps modulo the memory depth.
    assign w_word_idx = r_pc[NB_ADDR+1:2];
    assign w_pc_four  = r_pc + NB_REG'(PC_INC);

    instruction_memory #(
        .NB_REG  (NB_REG),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (i_imem_we),
        .i_waddr (i_imem_waddr),
        .i_wdata (i_imem_wdata),
        .i_raddr (w_word_idx),
        .o_rdata (w_instruction)
    );

`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
    fetch_state_e r_state;
    logic         r_halted;
    logic         w_halt_fetch;
    logic         w_redirect;

    assign w_halt_fetch = (w_instruction == NB_REG'(HALT_INSTR));
    assign w_redirect   = i_jump | i_branch_taken;
    assign w_advance    = i_dunit_clk_en & i_pc_write & (r_state == RUN);

    always_comb begin
        w_pc_next = w_pc_four;
        if (i_jump) begin
            w_pc_next = i_jump_addr & ~NB_REG'(2'b11);
        end else if (i_branch_taken) begin
            w_pc_next = i_branch_addr & ~NB_REG'(2'b11);
        end else if (w_halt_fetch) begin
            w_pc_next = r_pc;
        end
    end

    // A redirect on the halt word wins; the halt word is flushed downstream.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc     <= NB_REG'(PC_RESET);
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else if (w_advance) begin
            r_pc <= w_pc_next;
            if (!w_redirect && w_halt_fetch) begin
                r_state  <= HALTED;
                r_halted <= 1'b1;
            end
        end
    end

    assign o_halted = r_halted;
`else
    assign w_advance = i_dunit_clk_en & i_pc_write;

    always_comb begin
        w_pc_next = w_pc_four;
        if (i_jump) begin
            w_pc_next = i_jump_addr & ~NB_REG'(2'b11);
        end else if (i_branch_taken) begin
            w_pc_next = i_branch_addr & ~NB_REG'(2'b11);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc <= NB_REG'(PC_RESET);
        end else if (w_advance) begin
            r_pc <= w_pc_next;
        end
    end

    assign o_halted = 1'b0;
`endif

    assign o_pc          = r_pc;
    assign o_pc_four     = w_pc_four;
    assign o_instruction = w_instruction;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch against an array-based reference model.
module tb_instruction_fetch;

`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_dunit_clk_en = 1'b0;
    logic        i_pc_write = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [31:0] i_branch_addr = '0;
    logic        i_jump = 1'b0;
    logic [31:0] i_jump_addr = '0;
    logic        i_imem_we = 1'b0;
    logic [7:0]  i_imem_waddr = '0;
    logic [31:0] i_imem_wdata = '0;
    logic [31:0] o_pc, o_pc_four, o_instruction;
    logic        o_halted;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_mem [256];
    logic [31:0] m_pc = '0;
    bit          m_halted = 1'b0;

    instruction_fetch #(.NB_REG(32), .NB_ADDR(8)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_dunit_clk_en (i_dunit_clk_en),
        .i_pc_write     (i_pc_write),
        .i_branch_taken (i_branch_taken),
        .i_branch_addr  (i_branch_addr),
        .i_jump         (i_jump),
        .i_jump_addr    (i_jump_addr),
        .i_imem_we      (i_imem_we),
        .i_imem_waddr   (i_imem_waddr),
        .i_imem_wdata   (i_imem_wdata),
        .o_pc           (o_pc),
        .o_pc_four      (o_pc_four),
        .o_instruction  (o_instruction),
        .o_halted       (o_halted)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] m_instr();
        return m_mem[m_pc[9:2]];
    endfunction

    // Drive one cycle of inputs, advance the model by the fetch rules, then cross the edge.
    task automatic tick(input bit en, input bit pw, input bit br, input logic [31:0] ba,
                        input bit jp, input logic [31:0] ja, input bit we,
                        input logic [7:0] wa, input logic [31:0] wd);
        logic [31:0] cur;
        cur = m_instr();
        i_dunit_clk_en = en; i_pc_write = pw;
        i_branch_taken = br; i_branch_addr = ba;
        i_jump = jp; i_jump_addr = ja;
        i_imem_we = we; i_imem_waddr = wa; i_imem_wdata = wd;
        if (i_reset_n && en && pw && !m_halted) begin
            if (jp)                                   m_pc = ja & 32'hFFFF_FFFC;
            else if (br)                              m_pc = ba & 32'hFFFF_FFFC;
            else if (HALT_EN && cur == 32'hFFFF_FFFF) m_halted = 1'b1;
            else                                      m_pc = m_pc + 32'd4;
        end
        if (we) m_mem[wa] = wd;
        @(posedge i_clk);
        #1;
    endtask

    task automatic run1();
        tick(1, 1, 0, '0, 0, '0, 0, '0, '0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        m_pc = '0;
        m_halted = 1'b0;
        #3;
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] w;
        i_reset_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            w = $urandom() & 32'hFFFF_FFFE;
            tick(1, 1, 0, '0, 0, '0, 1, 8'(i), w);
        end
        tick(0, 0, 0, '0, 0, '0, 1, 8'd0, 32'h2001_0001);
        tick(0, 0, 0, '0, 0, '0, 1, 8'd1, 32'h2002_0002);
        tick(0, 0, 0, '0, 0, '0, 1, 8'd2, 32'h2003_0003);
        tick(0, 0, 0, '0, 0, '0, 1, 8'd3, 32'hFFFF_FFFF);
        i_imem_we = 1'b0;
        i_reset_n = 1'b1;
        n_cmp++; if (o_pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 32'd0); end
        n_cmp++; if (o_pc_four !== 32'd4) begin n_bad++; $display("FAIL reset_pc_four got=%h exp=%h", o_pc_four, 32'd4); end
        n_cmp++; if (o_halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got=%b exp=0", o_halted); end
        n_cmp++; if (o_instruction !== 32'h2001_0001) begin n_bad++; $display("FAIL reset_instr got=%h exp=%h", o_instruction, 32'h2001_0001); end
    endtask

    task automatic test_program_halt();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            run1();
            exp_pc = (i <= 3 || !HALT_EN) ? 32'(4 * i) : 32'd12;
            n_cmp++; if (o_pc !== exp_pc) begin n_bad++; $display("FAIL halt_pc[%0d] got=%h exp=%h", i, o_pc, exp_pc); end
            n_cmp++; if (o_halted !== (HALT_EN && i >= 4)) begin n_bad++; $display("FAIL halt_flag[%0d] got=%b exp=%b", i, o_halted, HALT_EN && i >= 4); end
            n_cmp++; if (o_instruction !== m_instr()) begin n_bad++; $display("FAIL halt_instr[%0d] got=%h exp=%h", i, o_instruction, m_instr()); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        run1(); run1();
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 0, '0, 0, '0, 0, '0, '0);
            n_cmp++; if (o_pc !== 32'd8) begin n_bad++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, o_pc, 32'd8); end
            n_cmp++; if (o_instruction !== 32'h2003_0003) begin n_bad++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, o_instruction, 32'h2003_0003); end
        end
        run1();
        n_cmp++; if (o_pc !== 32'd12) begin n_bad++; $display("FAIL stall_release got=%h exp=%h", o_pc, 32'd12); end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        run1();
        tick(1, 1, 1, 32'h22, 1, 32'h40, 0, '0, '0);
        n_cmp++; if (o_pc !== 32'h40) begin n_bad++; $display("FAIL jump_wins got=%h exp=%h", o_pc, 32'h40); end
        n_cmp++; if (o_instruction !== m_instr()) begin n_bad++; $display("FAIL jump_instr got=%h exp=%h", o_instruction, m_instr()); end
        do_reset();
        run1();
        tick(1, 1, 1, 32'h22, 0, 32'h40, 0, '0, '0);
        n_cmp++; if (o_pc !== 32'h20) begin n_bad++; $display("FAIL branch_only got=%h exp=%h", o_pc, 32'h20); end
        tick(0, 1, 0, '0, 1, 32'h80, 0, '0, '0);
        n_cmp++; if (o_pc !== 32'h20) begin n_bad++; $display("FAIL jump_no_en got=%h exp=%h", o_pc, 32'h20); end
        tick(1, 1, 0, '0, 1, 32'hFFFF_FFFE, 0, '0, '0);
        n_cmp++; if (o_pc_four !== 32'd0) begin n_bad++; $display("FAIL wrap_pc_four got=%h exp=%h", o_pc_four, 32'd0); end
        n_cmp++; if (o_instruction !== m_mem[255]) begin n_bad++; $display("FAIL wrap_instr got=%h exp=%h", o_instruction, m_mem[255]); end
        run1();
        n_cmp++; if (o_pc !== 32'd0) begin n_bad++; $display("FAIL wrap_pc got=%h exp=%h", o_pc, 32'd0); end
    endtask

    task automatic test_halt_redirect();
        do_reset();
        run1(); run1(); run1();
        tick(1, 1, 0, '0, 1, 32'h0, 0, '0, '0);
        n_cmp++; if (o_pc !== 32'd0) begin n_bad++; $display("FAIL halt_redir_pc got=%h exp=%h", o_pc, 32'd0); end
        n_cmp++; if (o_halted !== 1'b0) begin n_bad++; $display("FAIL halt_redir_flag got=%b exp=0", o_halted); end
    endtask

    task automatic test_reset_rerun();
        do_reset();
        for (int i = 0; i < 5; i++) run1();
        tick(1, 1, 0, '0, 0, '0, 1, 8'd3, 32'h0);
        i_imem_we = 1'b0;
        #2;
        i_reset_n = 1'b0;
        m_pc = '0; m_halted = 1'b0;
        #1;
        n_cmp++; if (o_pc !== 32'd0) begin n_bad++; $display("FAIL async_rst_pc got=%h exp=%h", o_pc, 32'd0); end
        n_cmp++; if (o_halted !== 1'b0) begin n_bad++; $display("FAIL async_rst_halted got=%b exp=0", o_halted); end
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) run1();
        n_cmp++; if (o_pc !== 32'd16) begin n_bad++; $display("FAIL rerun_pc got=%h exp=%h", o_pc, 32'd16); end
        n_cmp++; if (o_halted !== 1'b0) begin n_bad++; $display("FAIL rerun_halted got=%b exp=0", o_halted); end
        tick(0, 0, 0, '0, 0, '0, 1, 8'd3, 32'hFFFF_FFFF);
    endtask

    task automatic test_clk_en();
        do_reset();
        run1();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                n_cmp++; if (o_instruction !== 32'h2002_0002) begin n_bad++; $display("FAIL wr_old got=%h exp=%h", o_instruction, 32'h2002_0002); end
                tick(0, 1, 0, '0, 0, '0, 1, 8'd1, 32'h1234_5678);
                n_cmp++; if (o_instruction !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_new got=%h exp=%h", o_instruction, 32'h1234_5678); end
            end else begin
                tick(0, 1, 0, '0, 1, 32'h100, 0, '0, '0);
            end
            n_cmp++; if (o_pc !== 32'd4) begin n_bad++; $display("FAIL clk_en_pc[%0d] got=%h exp=%h", i, o_pc, 32'd4); end
        end
        run1();
        n_cmp++; if (o_pc !== 32'd8) begin n_bad++; $display("FAIL clk_en_resume got=%h exp=%h", o_pc, 32'd8); end
        tick(0, 0, 0, '0, 0, '0, 1, 8'd1, 32'h2002_0002);
    endtask

    task automatic test_random();
        bit en, pw, br, jp, we;
        logic [31:0] ba, ja, wd;
        logic [7:0] wa;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            en = ($urandom_range(0, 7) != 0);
            pw = ($urandom_range(0, 5) != 0);
            br = ($urandom_range(0, 9) == 0);
            jp = ($urandom_range(0, 14) == 0);
            ba = $urandom();
            ja = $urandom();
            we = ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 1) == 0) ? m_pc[9:2] : 8'($urandom());
            wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            tick(en, pw, br, ba, jp, ja, we, wa, wd);
            n_cmp++; if (o_pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, o_pc, m_pc); end
            n_cmp++; if (o_pc_four !== m_pc + 32'd4) begin n_bad++; $display("FAIL rnd_pc_four[%0d] got=%h exp=%h", i, o_pc_four, m_pc + 32'd4); end
            n_cmp++; if (o_instruction !== m_instr()) begin n_bad++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", i, o_instruction, m_instr()); end
            n_cmp++; if (o_halted !== m_halted) begin n_bad++; $display("FAIL rnd_halted[%0d] got=%b exp=%b", i, o_halted, m_halted); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_program_halt();
        test_stall();
        test_redirect_priority();
        test_halt_redirect();
        test_reset_rerun();
        test_clk_en();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
